uart_rx_frame: RTL and testbench

- UART receiver in the RX clock domain, directly upstream of the system controller (via the data synchroniser).
- Oversamples RX_IN at Prescale x baud and majority-votes each bit.
- Checks start glitch, parity and stop bit.
- Outputs the deserialised byte with a one-cycle valid pulse; this becomes Rx_P_Data / Rx_D_VLD downstream.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_frame_if.sv | 26 ++
 rtl/uart_rx_sampler.sv | 54 +++++
 rtl/uart_rx_frame.sv | 138 +++++++++++++
 tb/tb_uart_rx_frame.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path: FSM encoding, legal oversampling
// ratios and parity types.
package uart_rx_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Anything other than 16 or 32 falls back to x8 oversampling.
  function automatic int unsigned legal_prescale(input int unsigned p);
    return ((p == PRESCALE_16) || (p == PRESCALE_32)) ? p : PRESCALE_8;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Serial line, per-frame configuration and received-byte outputs of the UART receiver.
interface uart_rx_frame_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
);

  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] Prescale;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VLD;
  logic                  PAR_ERR;
  logic                  STP_ERR;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale,
    input  P_DATA, DATA_VLD, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale,
    output P_DATA, DATA_VLD, PAR_ERR, STP_ERR
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three mid-bit captures and a 2-of-3 majority vote.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  active_i,
  input  logic                  rx_s_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  sampled_bit_c_o,
  output logic                  bit_done_c_o
);

  localparam int unsigned PW = PRESCALE_W;

  logic [PW-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]    samp_q, samp_d;
  logic [PW-1:0] half;

  // Counter wraps at P-1; captures straddle the bit centre.
  always_comb begin
    edge_cnt_d   = edge_cnt_q;
    samp_d       = samp_q;
    half         = prescale_i >> 1;
    bit_done_c_o = active_i && (edge_cnt_q == (prescale_i - PW'(1)));
    if (!active_i || bit_done_c_o) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + PW'(1);
    end
    if (active_i) begin
      if (edge_cnt_q == (half - PW'(1))) samp_d[0] = rx_s_i;
      if (edge_cnt_q == half)            samp_d[1] = rx_s_i;
      if (edge_cnt_q == (half + PW'(1))) samp_d[2] = rx_s_i;
    end
  end

  assign sampled_bit_c_o = (samp_q[0] & samp_q[1]) |
                           (samp_q[0] & samp_q[2]) |
                           (samp_q[1] & samp_q[2]);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= '0;
      samp_q     <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      samp_q     <= samp_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronises RX_IN, walks start/data/parity/stop bits and
// reports the byte or parity/stop errors as single-cycle registered pulses.
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic           CLK,
  input  logic           RST,
  uart_rx_frame_if.slave rx_if
);

  localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [1:0]            sync_q;
  logic                  rx_s;
  logic [STATE_W-1:0]    state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_flag_q, par_flag_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_vld_q, data_vld_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  sampled_bit;
  logic                  bit_done;

  assign rx_s = sync_q[1];

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .CLK             (CLK),
    .RST             (RST),
    .active_i        (state_q != ST_IDLE),
    .rx_s_i          (rx_s),
    .prescale_i      (prescale_q),
    .sampled_bit_c_o (sampled_bit),
    .bit_done_c_o    (bit_done)
  );

  // Next-state and output decode; pulses default low so they last one cycle.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_flag_d = par_flag_q;
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    p_data_d   = p_data_q;
    data_vld_d = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d    = ST_START;
          prescale_d = PRESCALE_W'(legal_prescale(32'(rx_if.Prescale)));
          par_en_d   = rx_if.PAR_EN;
          par_typ_d  = rx_if.PAR_TYP;
          par_flag_d = 1'b0;
          bit_cnt_d  = '0;
        end
      end
      ST_START: begin
        if (bit_done) state_d = sampled_bit ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          par_flag_d = sampled_bit ^ (^shift_q) ^ par_typ_q;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          stp_err_d = !sampled_bit;
          par_err_d = par_flag_q;
          if (sampled_bit && !par_flag_q) begin
            p_data_d   = shift_q;
            data_vld_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q     <= 2'b11;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_flag_q <= 1'b0;
      prescale_q <= PRESCALE_W'(PRESCALE_8);
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      p_data_q   <= '0;
      data_vld_q <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx_if.RX_IN};
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_flag_q <= par_flag_d;
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      p_data_q   <= p_data_d;
      data_vld_q <= data_vld_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  assign rx_if.P_DATA   = p_data_q;
  assign rx_if.DATA_VLD = data_vld_q;
  assign rx_if.PAR_ERR  = par_err_q;
  assign rx_if.STP_ERR  = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: a frame-level driver predicts each output
// pulse (kind, byte, cycle) and an independent monitor checks what the DUT emits.
module tb_uart_rx_frame;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  uart_rx_frame_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) rx_if ();

  uart_rx_frame #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .rx_if (rx_if)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]      pdata;
    bit              vld;
    bit              perr;
    bit              serr;
    longint unsigned cyc;
  } exp_t;

  exp_t            sb_q[$];
  longint unsigned cyc = 0;
  longint unsigned free_cyc = 0;  // cycle at which the receiver last finished a frame
  logic [7:0]      last_good = 8'h00;
  int              checks = 0;
  int              failures = 0;
  bit              prev_gap_zero = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic int unsigned legal_p(input int unsigned p_raw);
    return (p_raw == 16 || p_raw == 32) ? p_raw : 8;
  endfunction

  // Sends one complete frame and predicts its outcome.
  task automatic send_frame(input int unsigned p_raw, input bit pen, input bit ptyp,
                            input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int unsigned gap_bits);
    int unsigned     p;
    int unsigned     nbits;
    longint unsigned t_edge;
    longint unsigned t_start;
    exp_t            e;
    p     = legal_p(p_raw);
    nbits = 10 + 32'(pen);
    rx_if.Prescale = 6'(p_raw);
    rx_if.PAR_EN   = pen;
    rx_if.PAR_TYP  = ptyp;
    // Line edge is seen by the first input flop at the next rising edge; two
    // flops later IDLE can react, but never before the previous frame ended.
    t_edge  = cyc + 1;
    t_start = (t_edge + 2 > free_cyc + 1) ? t_edge + 2 : free_cyc + 1;
    e.cyc   = t_start + longint'(nbits * p);
    e.serr  = bad_stop;
    e.perr  = pen & bad_par;
    e.vld   = !e.serr && !e.perr;
    if (e.vld) last_good = d;
    e.pdata = last_good;
    sb_q.push_back(e);
    free_cyc = e.cyc;

    rx_if.RX_IN = 1'b0;
    tick(4);
    rx_if.Prescale = 6'($urandom_range(0, 63));
    rx_if.PAR_EN   = 1'($urandom);
    rx_if.PAR_TYP  = 1'($urandom);
    tick(p - 4);
    for (int i = 0; i < 8; i++) begin
      rx_if.RX_IN = d[i];
      tick(p);
    end
    if (pen) begin
      rx_if.RX_IN = (^d) ^ ptyp ^ bad_par;
      tick(p);
    end
    rx_if.RX_IN = !bad_stop;
    tick(p);
    rx_if.RX_IN = 1'b1;
    tick(gap_bits * p);
  endtask

  // Monitor: every output pulse must match the oldest outstanding prediction.
  always @(negedge CLK) begin
    exp_t e;
    if (rx_if.DATA_VLD || rx_if.PAR_ERR || rx_if.STP_ERR) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse vld=%0b perr=%0b serr=%0b p_data=%0h cycle=%0d",
                 rx_if.DATA_VLD, rx_if.PAR_ERR, rx_if.STP_ERR, rx_if.P_DATA, cyc);
      end else begin
        e = sb_q.pop_front();
        check("data_vld", 64'(rx_if.DATA_VLD), 64'(e.vld));
        check("par_err", 64'(rx_if.PAR_ERR), 64'(e.perr));
        check("stp_err", 64'(rx_if.STP_ERR), 64'(e.serr));
        check("p_data", 64'(rx_if.P_DATA), 64'(e.pdata));
        check("pulse_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired cycle=%0d pending=%0d", cyc, sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned praw [6] = '{8, 16, 32, 0, 12, 63};
    int unsigned w;
    rx_if.RX_IN    = 1'b1;
    rx_if.PAR_EN   = 1'b0;
    rx_if.PAR_TYP  = 1'b0;
    rx_if.Prescale = 6'd8;
    tick(3);
    check("reset_p_data", 64'(rx_if.P_DATA), 64'h0);
    check("reset_data_vld", 64'(rx_if.DATA_VLD), 64'h0);
    check("reset_par_err", 64'(rx_if.PAR_ERR), 64'h0);
    check("reset_stp_err", 64'(rx_if.STP_ERR), 64'h0);
    RST = 1'b1;
    tick(3);
    free_cyc = cyc;

    send_frame(8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 2);
    send_frame(8, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 2);
    send_frame(16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 2);
    send_frame(16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 2);

    // Two-cycle start glitch must be rejected silently.
    rx_if.Prescale = 6'd8;
    rx_if.RX_IN    = 1'b0;
    tick(2);
    rx_if.RX_IN = 1'b1;
    tick(24);
    send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 2);

    send_frame(32, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 0);
    send_frame(32, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 2);

    // Reset in the middle of the data bits of a 0xFF frame.
    rx_if.Prescale = 6'd8;
    rx_if.PAR_EN   = 1'b0;
    rx_if.RX_IN    = 1'b0;
    tick(8);
    rx_if.RX_IN = 1'b1;
    tick(20);
    RST = 1'b0;
    tick(1);
    check("midreset_p_data", 64'(rx_if.P_DATA), 64'h0);
    check("midreset_data_vld", 64'(rx_if.DATA_VLD), 64'h0);
    tick(4);
    check("midreset_par_err", 64'(rx_if.PAR_ERR), 64'h0);
    check("midreset_stp_err", 64'(rx_if.STP_ERR), 64'h0);
    last_good = 8'h00;
    RST = 1'b1;
    tick(2);
    free_cyc = cyc;
    check("post_reset_p_data", 64'(rx_if.P_DATA), 64'h0);
    send_frame(8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 2);

    prev_gap_zero = 1'b0;
    for (int n = 0; n < 40; n++) begin
      int unsigned gap;
      gap = prev_gap_zero ? $urandom_range(1, 2) : $urandom_range(0, 2);
      prev_gap_zero = (gap == 0);
      send_frame(praw[$urandom_range(0, 5)], 1'($urandom), 1'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), gap);
    end

    tick(8);
    w = 0;
    while (sb_q.size() != 0 && w < 5000) begin
      tick(1);
      w++;
    end
    check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    check("final_p_data", 64'(rx_if.P_DATA), 64'(last_good));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
